// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encoding, the
// DIV/DIVU ALU op codes decoded by execute, and the operand magnitude helper.
package div_unit_pkg;

   localparam int DataWidth = 32;

   localparam logic [7:0] AluOpDiv  = 8'b0001_1010;
   localparam logic [7:0] AluOpDivu = 8'b0001_1011;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } divState_e;

   // In signed mode a negative operand is negated; 0x80000000 stays 0x80000000,
   // which is exactly its magnitude when read as unsigned.
   function automatic logic [DataWidth-1:0] magnitude(input logic [DataWidth-1:0] value,
                                                      input logic signedMode);
      return (signedMode && value[DataWidth-1]) ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the shifted
// 33-bit partial remainder, keeping the difference only when it does not borrow.
module div_step
   import div_unit_pkg::*;
(
   input  logic [DataWidth:0]   remIn_i,
   input  logic [DataWidth-1:0] divisor_i,
   output logic [DataWidth-1:0] remOut_o,
   output logic                 qBit_o
);

   logic [DataWidth-1:0] diff;

   // A kept difference is always below the divisor, so the low 32 bits of
   // the subtraction are the whole new remainder.
   assign qBit_o   = (remIn_i >= {1'b0, divisor_i});
   assign diff     = remIn_i[DataWidth-1:0] - divisor_i;
   assign remOut_o = qBit_o ? diff : remIn_i[DataWidth-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit: one quotient bit per clock, 32 iterations,
// result delivered as {remainder, quotient} for the HI/LO write.
module div_unit
   import div_unit_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   signed_div_i,
   input  logic [DataWidth-1:0]   opdata1_i,
   input  logic [DataWidth-1:0]   opdata2_i,
   input  logic                   start_i,
   input  logic                   annul_i,
   output logic [2*DataWidth-1:0] result_o,
   output logic                   ready_o
);

   divState_e              state_q;
   logic [4:0]             cnt_q;
   logic [2*DataWidth-1:0] pr_q;
   logic [DataWidth-1:0]   divisor_q;
   logic                   negQuot_q;
   logic                   negRem_q;

   logic [DataWidth-1:0]   remStep_d;
   logic                   qBit_d;
   logic [2*DataWidth-1:0] pr_d;
   logic [DataWidth-1:0]   quot_d;
   logic [DataWidth-1:0]   rem_d;

   // pr_q holds {partial remainder, dividend bits not yet consumed / quotient bits so far}.
   div_step uStep (
      .remIn_i  (pr_q[2*DataWidth-1:DataWidth-1]),
      .divisor_i(divisor_q),
      .remOut_o (remStep_d),
      .qBit_o   (qBit_d)
   );

   assign pr_d   = {remStep_d, pr_q[DataWidth-2:0], qBit_d};
   assign quot_d = negQuot_q ? (~pr_d[DataWidth-1:0] + 32'd1) : pr_d[DataWidth-1:0];
   assign rem_d  = negRem_q ? (~pr_d[2*DataWidth-1:DataWidth] + 32'd1)
                            : pr_d[2*DataWidth-1:DataWidth];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= DivFree;
         cnt_q     <= '0;
         pr_q      <= '0;
         divisor_q <= '0;
         negQuot_q <= 1'b0;
         negRem_q  <= 1'b0;
         result_o  <= '0;
         ready_o   <= 1'b0;
      end else begin
         case (state_q)
            DivFree: begin
               result_o <= '0;
               ready_o  <= 1'b0;
               if (start_i && !annul_i) begin
                  pr_q      <= {{DataWidth{1'b0}}, magnitude(opdata1_i, signed_div_i)};
                  divisor_q <= magnitude(opdata2_i, signed_div_i);
                  negQuot_q <= signed_div_i & (opdata1_i[DataWidth-1] ^ opdata2_i[DataWidth-1]);
                  negRem_q  <= signed_div_i & opdata1_i[DataWidth-1];
                  cnt_q     <= '0;
                  state_q   <= (opdata2_i == '0) ? DivByZero : DivOn;
               end
            end
            DivByZero: begin
               if (annul_i) begin
                  state_q <= DivFree;
               end else begin
                  result_o <= '0;
                  ready_o  <= 1'b1;
                  state_q  <= DivEnd;
               end
            end
            DivOn: begin
               // An annul on the final iteration still wins over completion.
               if (annul_i) begin
                  cnt_q    <= '0;
                  result_o <= '0;
                  ready_o  <= 1'b0;
                  state_q  <= DivFree;
               end else begin
                  pr_q  <= pr_d;
                  cnt_q <= cnt_q + 5'd1;
                  if (cnt_q == 5'd31) begin
                     result_o <= {rem_d, quot_d};
                     ready_o  <= 1'b1;
                     state_q  <= DivEnd;
                  end
               end
            end
            DivEnd: begin
               if (!start_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b0;
                  state_q  <= DivFree;
               end
            end
            default: state_q <= DivFree;
         endcase
      end
   end

endmodule
